// File: rtl/crypto_rng_sequencer.sv
// Xorshift32 random-byte sequencer controlled by Nios PIO seed/control words.
// LOAD seeds and warms up the generator, REQ runs a byte generation with a
// 4-phase handshake, CLR_ERR clears the sticky protocol-error flag.
module crypto_rng_sequencer #(
    parameter int unsigned WARMUP_STEPS = 16,
    parameter int unsigned GEN_STEPS    = 8,
    parameter logic [31:0] ZERO_SUB     = 32'h2545F491
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] seed_i,
    input  logic [7:0]  ctrl_i,
    output logic [7:0]  random_o,
    output logic [7:0]  status_o
);

    localparam int unsigned MAX_STEPS = (WARMUP_STEPS > GEN_STEPS) ? WARMUP_STEPS : GEN_STEPS;
    localparam int unsigned CNT_W     = $clog2(MAX_STEPS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_READY,
        S_GEN,
        S_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        x_q, x_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         rnd_q, rnd_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               seeded_q, seeded_d;
    logic               err_q, err_d;
    logic [2:0]         ctrl_q;

    logic               load_edge;
    logic               req_edge;
    logic               clr_edge;
    logic               unused_ctrl;

    // One xorshift32 step (13, 17, 5).
    function automatic logic [31:0] xs_step(input logic [31:0] v);
        logic [31:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    assign load_edge   = ctrl_i[0] & ~ctrl_q[0];
    assign req_edge    = ctrl_i[1] & ~ctrl_q[1];
    assign clr_edge    = ctrl_i[2] & ~ctrl_q[2];
    assign unused_ctrl = ^ctrl_i[7:3];

    // Next-state, datapath and flag logic; LOAD overrides every state.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        rnd_d    = rnd_q;
        valid_d  = valid_q;
        seeded_d = seeded_q;
        err_d    = err_q;

        if (clr_edge) begin
            err_d = 1'b0;
        end

        if (load_edge) begin
            x_d      = (seed_i == 32'h0) ? ZERO_SUB : seed_i;
            seeded_d = 1'b0;
            valid_d  = 1'b0;
            if (WARMUP_STEPS == 0) begin
                // No warmup: generator is usable immediately; a same-cycle REQ is dropped.
                cnt_d    = '0;
                seeded_d = 1'b1;
                state_d  = S_READY;
            end else begin
                cnt_d   = CNT_W'(WARMUP_STEPS);
                state_d = S_WARMUP;
                if (req_edge) begin
                    err_d = 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_edge) begin
                        err_d = 1'b1;
                    end
                end
                S_WARMUP: begin
                    if (req_edge) begin
                        err_d = 1'b1;
                    end
                    x_d = xs_step(x_q);
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d    = '0;
                        seeded_d = 1'b1;
                        state_d  = S_READY;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_READY: begin
                    if (req_edge) begin
                        cnt_d   = CNT_W'(GEN_STEPS);
                        state_d = S_GEN;
                    end
                end
                S_GEN: begin
                    if (cnt_q != '0) begin
                        x_d   = xs_step(x_q);
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        rnd_d   = x_q[7:0];
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!ctrl_i[1]) begin
                        valid_d = 1'b0;
                        state_d = S_READY;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_WARMUP) || (state_d == S_GEN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            cnt_q    <= '0;
            rnd_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            seeded_q <= 1'b0;
            err_q    <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            rnd_q    <= rnd_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            seeded_q <= seeded_d;
            err_q    <= err_d;
            ctrl_q   <= ctrl_i[2:0];
        end
    end

    assign random_o = rnd_q;
    assign status_o = {4'b0000, err_q, seeded_q, busy_q, valid_q};

endmodule

// File: tb/tb_crypto_rng_sequencer.sv
// Bench for crypto_rng_sequencer: two instances (default parameters and
// WARMUP_STEPS=0/GEN_STEPS=1), a step-count reference model and a scoreboard.
module tb_crypto_rng_sequencer;

    localparam logic [31:0] ZSUB = 32'h2545F491;

    typedef struct packed {
        logic [7:0] b;
        int         t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] seed;
    logic [7:0]  ctrl0, ctrl1;
    logic [7:0]  rnd0, rnd1, st0, st1;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        rst_seen = 1'b0;

    logic [31:0] mx [2];
    int unsigned pw [2];
    int unsigned pg [2];
    exp_t        q0 [$];
    exp_t        q1 [$];
    logic        pv [2];
    logic [7:0]  pr [2];

    always #5 clk = ~clk;

    crypto_rng_sequencer u_def (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .seed_i        (seed),
        .ctrl_i        (ctrl0),
        .random_o      (rnd0),
        .status_o      (st0)
    );

    crypto_rng_sequencer #(
        .WARMUP_STEPS (0),
        .GEN_STEPS    (1)
    ) u_fast (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .seed_i        (seed),
        .ctrl_i        (ctrl1),
        .random_o      (rnd1),
        .status_o      (st1)
    );

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    // Reference model: xorshift32 advanced by a count of steps.
    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [31:0] advance(input logic [31:0] v, input int unsigned n);
        logic [31:0] t;
        t = v;
        for (int unsigned i = 0; i < n; i++) t = xs(t);
        return t;
    endfunction

    function automatic logic [7:0] get_st(input int d);
        return (d == 0) ? st0 : st1;
    endfunction

    function automatic logic [7:0] get_rnd(input int d);
        return (d == 0) ? rnd0 : rnd1;
    endfunction

    task automatic set_ctrl(input int d, input logic [7:0] v);
        if (d == 0) ctrl0 = v;
        else        ctrl1 = v;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every VALID rise; otherwise random_o must hold.
    task automatic mon(input int d);
        logic [7:0] s;
        logic [7:0] r;
        exp_t       e;
        int         sz;
        s  = get_st(d);
        r  = get_rnd(d);
        sz = (d == 0) ? q0.size() : q1.size();
        if (s[0] && !pv[d]) begin
            if (sz == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_byte dut%0d: got %h, expected no VALID (cycle %0d)", d, r, cyc);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("byte dut%0d", d), 32'(r), 32'(e.b));
                check($sformatf("latency dut%0d", d), 32'(cyc), 32'(e.t));
            end
        end else begin
            check($sformatf("rnd_stable dut%0d", d), 32'(r), 32'(pr[d]));
        end
    endtask

    always @(negedge clk) begin
        if (rst_seen) begin
            mon(0);
            mon(1);
        end
        pv[0] = st0[0];
        pv[1] = st1[0];
        pr[0] = rnd0;
        pr[1] = rnd1;
    end

    task automatic do_load(input int d, input logic [31:0] s);
        seed  = s;
        mx[d] = advance((s == 32'h0) ? ZSUB : s, pw[d]);
        set_ctrl(d, 8'h01);
        @(negedge clk);
        set_ctrl(d, 8'h00);
        repeat (pw[d] + 1) @(negedge clk);
    endtask

    task automatic do_req(input int d, input int hold);
        logic [7:0] s;
        logic       seen;
        exp_t       e;
        set_ctrl(d, 8'h02);
        mx[d] = advance(mx[d], pg[d]);
        e.b   = mx[d][7:0];
        e.t   = cyc + int'(pg[d]) + 2;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < int'(pg[d]) + 6 && !seen; k++) begin
            @(negedge clk);
            s    = get_st(d);
            seen = s[0];
        end
        check($sformatf("valid_seen dut%0d", d), 32'(seen), 32'd1);
        repeat (hold) @(negedge clk);
        set_ctrl(d, 8'h00);
        @(negedge clk);
        s = get_st(d);
        check($sformatf("valid_drop dut%0d", d), 32'(s[0]), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int          n_busy;
        int          d;
        logic [31:0] s;
        logic [7:0]  st;

        pw[0] = 16; pg[0] = 8;
        pw[1] = 0;  pg[1] = 1;
        pv[0] = 1'b0; pv[1] = 1'b0;
        pr[0] = 8'h00; pr[1] = 8'h00;
        rst_n = 1'b0;
        seed  = 32'h0;
        ctrl0 = 8'h00;
        ctrl1 = 8'h00;
        repeat (3) @(negedge clk);

        check("reset status0", 32'(st0), 32'h0);
        check("reset random0", 32'(rnd0), 32'h0);
        check("reset status1", 32'(st1), 32'h0);
        check("reset random1", 32'(rnd1), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // REQ before any LOAD raises ERR only; CLR_ERR clears it.
        ctrl0 = 8'h02;
        @(negedge clk);
        check("req_idle status", 32'(st0), 32'h08);
        check("req_idle random", 32'(rnd0), 32'h0);
        ctrl0 = 8'h00;
        @(negedge clk);
        ctrl0 = 8'h04;
        @(negedge clk);
        ctrl0 = 8'h00;
        check("clr_err status", 32'(st0), 32'h00);

        // Fast instance: seed 1, one step gives 32'h00042021.
        do_load(1, 32'h1);
        do_req(1, 2);
        check("seed1 byte", 32'(rnd1), 32'h21);

        // Zero seed on default instance: BUSY for exactly WARMUP_STEPS cycles.
        seed  = 32'h0;
        mx[0] = advance(ZSUB, pw[0]);
        ctrl0 = 8'h01;
        @(negedge clk);
        ctrl0  = 8'h00;
        n_busy = 0;
        for (int k = 0; k < 40; k++) begin
            st = st0;
            if (!st[1]) break;
            n_busy++;
            @(negedge clk);
        end
        check("warmup busy cycles", 32'(n_busy), 32'd16);
        check("warmup done status", 32'(st0), 32'h04);
        do_req(0, 3);

        // Randomized reloads and requests on both instances.
        for (int i = 0; i < 14; i++) begin
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                s = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
                do_load(d, s);
            end
            do_req(d, int'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // LOAD in mid-GEN aborts the byte and restarts warmup.
        ctrl0 = 8'h02;
        repeat (3) @(negedge clk);
        s     = $urandom | 32'h1;
        seed  = s;
        mx[0] = advance(s, pw[0]);
        ctrl0 = 8'h03;
        @(negedge clk);
        check("abort gen status", 32'(st0), 32'h02);
        ctrl0 = 8'h00;
        repeat (4) @(negedge clk);

        // Reset in mid-WARMUP, with LOAD already high when reset releases.
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset status0", 32'(st0), 32'h0);
        check("midreset random0", 32'(rnd0), 32'h0);
        check("midreset status1", 32'(st1), 32'h0);
        s     = $urandom | 32'h1;
        seed  = s;
        mx[0] = advance(s, pw[0]);
        ctrl0 = 8'h01;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("load_level_after_reset", 32'(st0), 32'h02);
        ctrl0 = 8'h00;
        repeat (pw[0] + 1) @(negedge clk);
        do_req(0, 1);

        // LOAD and REQ in the same cycle: LOAD wins, REQ counts as during WARMUP.
        s     = $urandom | 32'h1;
        seed  = s;
        mx[0] = advance(s, pw[0]);
        ctrl0 = 8'h03;
        @(negedge clk);
        check("load_req_same status", 32'(st0), 32'h0A);
        ctrl0 = 8'h00;
        repeat (pw[0] + 1) @(negedge clk);
        check("err sticky status", 32'(st0), 32'h0C);

        // CLR_ERR together with an erroring REQ leaves ERR set.
        s     = $urandom | 32'h1;
        seed  = s;
        mx[0] = advance(s, pw[0]);
        ctrl0 = 8'h01;
        @(negedge clk);
        ctrl0 = 8'h06;
        @(negedge clk);
        check("clr_with_req status", 32'(st0), 32'h0A);
        ctrl0 = 8'h00;
        repeat (pw[0]) @(negedge clk);
        ctrl0 = 8'h04;
        @(negedge clk);
        ctrl0 = 8'h00;
        check("clr_after status", 32'(st0), 32'h04);
        do_req(0, 2);

        // Reseed the fast instance after the reset and draw a few more bytes.
        do_load(1, $urandom);
        for (int i = 0; i < 4; i++) do_req(1, int'($urandom_range(0, 3)));

        repeat (5) @(negedge clk);
        check("queue0 drained", 32'(q0.size()), 32'd0);
        check("queue1 drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/crypto_rng_sequencer.md
CRYPTO_RNG_SEQUENCER -- requirements
Module: crypto_rng_sequencer

Interface
REQ-001 SHALL have parameter WARMUP_STEPS, default 16, xorshift steps run after each seed load before the block reports ready (0 permitted).
REQ-002 SHALL have parameter GEN_STEPS, default 8, xorshift steps run per byte request (minimum 1).
REQ-003 SHALL have parameter ZERO_SUB, default 32'h2545F491, substituted for an all-zero seed.
REQ-004 SHALL have port clk_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port seed_i  input  32  seed word from the Nios random-seed PIO.
REQ-007 SHALL have port ctrl_i  input  8  control from the Nios system-control PIO: bit0 LOAD, bit1 REQ, bit2 CLR_ERR, bits 7:3 ignored.
REQ-008 SHALL have port random_o  output  8  latched random byte, wired to the Nios random PIO.
REQ-009 SHALL have port status_o  output  8  bit0 VALID, bit1 BUSY, bit2 SEEDED, bit3 ERR, bits 7:4 zero.

Function
REQ-010 SHALL register ctrl_i once and act only on 0->1 edges of LOAD, REQ and CLR_ERR, detected against the registered copy.
REQ-011 SHALL keep a 32-bit state x, where one step is x^=x<<13, then x^=x>>17, then x^=x<<5, and one step completes per clock.
REQ-012 SHALL implement the FSM states IDLE, WARMUP, READY, GEN and HOLD.
REQ-013 In any state, a LOAD edge SHALL set x=seed_i (or ZERO_SUB if seed_i==0), clear SEEDED and VALID, load the step counter with WARMUP_STEPS, and go to WARMUP; if WARMUP_STEPS==0, go directly to READY.
REQ-014 WARMUP SHALL step x once per cycle and decrement the counter; after the last step it SHALL set SEEDED and go to READY.
REQ-015 In READY, a REQ edge SHALL load the counter with GEN_STEPS and go to GEN.
REQ-016 GEN SHALL step once per cycle; on the cycle after the final step it SHALL latch random_o=x[7:0], set VALID and go to HOLD.
REQ-017 Latency SHALL be GEN_STEPS+1 cycles from the cycle the REQ edge is registered to VALID high.
REQ-018 HOLD SHALL keep random_o and VALID stable until REQ is seen low, then clear VALID and return to READY (4-phase handshake).
REQ-019 random_o SHALL change only on VALID assertion or reset.
REQ-020 A REQ edge in IDLE or WARMUP SHALL set ERR and be otherwise ignored; a REQ edge in GEN or HOLD SHALL be ignored.
REQ-021 ERR SHALL be sticky until a CLR_ERR edge; if CLR_ERR and an erroring REQ edge occur in the same cycle, ERR SHALL end set.
REQ-022 BUSY SHALL be 1 exactly in WARMUP and GEN.
REQ-023 The step counter SHALL be wide enough for max(WARMUP_STEPS, GEN_STEPS) and SHALL never wrap below zero.
REQ-024 If LOAD and REQ edges occur in the same cycle, LOAD SHALL win and the REQ edge SHALL be treated as arriving during WARMUP (sets ERR unless WARMUP_STEPS==0).

Reset
REQ-025 When reset_reset_n is low at a clock edge, the block SHALL set state=IDLE, x=0, counter=0, random_o=8'h00, status_o=8'h00, and the ctrl_i history register to 0.
REQ-026 Reset asserted mid-WARMUP or mid-GEN SHALL abort the operation with no partial output; a LOAD is required afterwards.
REQ-027 After reset, a level-high LOAD already present SHALL count as an edge on the first registered cycle.

Verification
REQ-028 WARMUP_STEPS=0, GEN_STEPS=1: seed_i=1, LOAD pulse, REQ high -> x=32'h00042021 after one step, random_o=8'h21, VALID exactly 2 cycles after the REQ edge is registered.
REQ-029 seed_i=0, LOAD, defaults -> x begins from 32'h2545F491, BUSY high for 16 cycles, then SEEDED=1 and BUSY=0.
REQ-030 REQ before any LOAD -> ERR=1, VALID=0, random_o=8'h00; a CLR_ERR pulse -> ERR=0.
REQ-031 REQ held high across HOLD -> random_o stable and no second byte; REQ low -> VALID=0 next cycle; a second REQ gives a new byte after GEN_STEPS+1 cycles.
REQ-032 LOAD in mid-GEN -> VALID stays 0, state goes to WARMUP, SEEDED=0; and reset_reset_n low in mid-WARMUP -> status_o=8'h00 and random_o=8'h00 the next cycle.
